// File: rtl/noc_flit_pkg.sv
// Flit format shared by compute nodes, the injection buffer and the router.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package noc_flit_pkg;

  localparam int FLIT_W    = 71;
  localparam int PAYLOAD_W = 64;
  localparam int DEST_W    = 4;

  localparam int VALID_BIT = 70;
  localparam int HT_BIT    = 69;
  localparam int DEST_MSB  = 68;
  localparam int DEST_LSB  = 65;
  localparam int VC_BIT    = 64;

  localparam int NUM_VC    = 2;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic                 valid;
    logic                 ht;
    logic [DEST_W-1:0]    dest;
    logic                 vc;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

endpackage

// File: rtl/vc_credit_counter.sv
// Per-VC credit counter tracking free slots in the router input buffer (0..CREDITS).
// Latency: inc/dec take effect on the next clock edge; has_credit is a direct decode of the count.
// Backpressure: has_credit low stalls the sender; a return at CREDITS is clamped and flagged sticky.
module vc_credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic has_credit,
  output logic overflow_err
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Next count: simultaneous return and spend cancel; an extra return at the ceiling is an error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) begin
      if (cnt_q == CW'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and sticky error registers; reset restores a full credit pool.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(CREDITS);
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign has_credit   = (cnt_q != '0);
  assign overflow_err = err_q;

endmodule

// File: rtl/ni_inject_buffer.sv
// Injection buffer: captures node flits into a small FIFO and forwards them in order under per-VC credits.
// Latency: a flit sampled at edge k into an empty FIFO with credit drives out_valid after edge k+1.
// Backpressure: none toward the node (overflow flits are dropped and counted); router side is credit based.
module ni_inject_buffer #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int NUM_VC  = noc_flit_pkg::NUM_VC,
  parameter int CNT_W   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [noc_flit_pkg::FLIT_W-1:0] in_flit,
  input  logic                            in_send,
  output logic                            in_ready,
  output logic [noc_flit_pkg::FLIT_W-1:0] out_flit,
  output logic                            out_valid,
  input  logic [NUM_VC-1:0]               credit_in,
  output logic [$clog2(DEPTH):0]          fifo_count,
  output logic [CNT_W-1:0]                drop_count,
  output logic                            credit_err
);

  import noc_flit_pkg::*;

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  flit_t             mem_q [DEPTH];
  flit_t             mem_d [DEPTH];
  flit_t             out_flit_q, out_flit_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [AW:0]       count;
  logic              full, empty, push_req, pop;
  flit_t             head;
  logic [NUM_VC-1:0] has_credit, credit_dec, ovf_err;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign push_req = in_send && in_flit[VALID_BIT] && in_flit[HT_BIT];
  // Strict in-order issue: a credit-starved head blocks everything behind it.
  assign pop      = !empty && has_credit[head.vc];

  // Route the spend to the head flit's VC counter only.
  always_comb begin
    credit_dec          = '0;
    credit_dec[head.vc] = pop;
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_credit_counter #(
      .CREDITS (CREDITS)
    ) u_credit (
      .clk          (clk),
      .rst_n        (rst_n),
      .inc          (credit_in[v]),
      .dec          (credit_dec[v]),
      .has_credit   (has_credit[v]),
      .overflow_err (ovf_err[v])
    );
  end

  // FIFO, output register and drop counter next state; a pop frees a slot for a same-cycle push at full.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    drop_d      = drop_q;
    out_flit_d  = out_flit_q;
    out_valid_d = pop;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      out_flit_d = head;
    end
    if (push_req) begin
      if (!full || pop) begin
        mem_d[wr_ptr_q[AW-1:0]] = in_flit;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  // State registers; reset discards buffered flits without counting them as drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign in_ready   = !full;
  assign out_flit   = out_flit_q;
  assign out_valid  = out_valid_q;
  assign fifo_count = count;
  assign drop_count = drop_q;
  assign credit_err = |ovf_err;

endmodule

// File: doc/ni_inject_buffer.md
Name: ni_inject_buffer

Overview:
- Network-interface injection stage directly downstream of the compute nodes (adders and similar).
- Captures each result flit the node emits on its one-cycle ready_send pulse and buffers it in a small FIFO.
- Forwards flits to the local router port under per-VC credit flow control.
- Compute nodes have no backpressure input, so this block absorbs bursts and counts any overflow drops.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- CREDITS, 4, initial and maximum credits per VC (router input buffer depth)
- NUM_VC, 2, virtual channels; the VC id is flit bit 64
- CNT_W, 8, width of drop_count

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_flit  input  71  node flit: [70] valid, [69] head/tail, [68:65] dest, [64] vc, [63:0] payload
- in_send  input  1  one-cycle pulse from the node (its ready_send); in_flit is sampled on the same edge
- in_ready  output  1  high when the FIFO is not full (advisory only; nodes ignore it)
- out_flit  output  71  flit to the router
- out_valid  output  1  one-cycle pulse per flit sent
- credit_in  input  NUM_VC  per-VC credit-return pulses from the router
- fifo_count  output  $clog2(DEPTH)+1  current occupancy
- drop_count  output  CNT_W  saturating count of flits lost to overflow
- credit_err  output  1  sticky; set on a credit return while that VC is already at CREDITS

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, fifo_count=0, in_ready=1.
  - out_valid=0, out_flit=0, drop_count=0, credit_err=0.
  - Every credit counter = CREDITS.
- Push qualification: in_send=1 AND in_flit[70]=1 AND in_flit[69]=1.
  - in_send with either marker bit low is ignored silently; no drop count.
- Push when full: flit discarded; drop_count += 1, saturating at all-ones.
- Push when full with a pop in the same cycle: the push is accepted, no drop.
- Pop condition, evaluated each cycle: FIFO non-empty AND credit[head.vc] > 0.
  - On pop, the output register loads the head flit at the clock edge and out_valid=1 for exactly one cycle.
  - credit[head.vc] decrements on that edge.
- In-order only (head-of-line blocking): a blocked head on one VC stalls flits behind it on the other VC.
- No bypass. Latency: a flit sampled at edge k into an empty FIFO, with credit available, drives out_valid=1 after edge k+1.
  - Back-to-back pops give one flit per cycle.
- out_flit holds the last sent value while out_valid=0.
- Credit counter per VC, range 0..CREDITS:
  - credit_in[v] alone: +1.
  - Pop on v alone: -1.
  - Both in the same cycle: unchanged.
  - credit_in[v] while at CREDITS with no same-cycle pop: counter stays at CREDITS, credit_err set (cleared only by reset).
- Pointers are DEPTH-modulo with an extra wrap bit to distinguish full from empty. fifo_count = wr_ptr - rd_ptr.
- Reset mid-operation: all buffered flits are lost, credits restore to CREDITS, and drop_count is not incremented for them.
- No state machine beyond FIFO, credit counters and the output register; there are no stall cycles other than credit starvation.

Decomposition:
- Package noc_flit_pkg:
  - FLIT_W=71, PAYLOAD_W=64, DEST_W=4.
  - Bit-position constants: VALID_BIT=70, HT_BIT=69, DEST_MSB=68, DEST_LSB=65, VC_BIT=64.
  - NUM_VC default.
  - Packed flit struct typedef.
  - The package is shared with the compute nodes and the router.
- Sub-module vc_credit_counter: one instance per VC.
  - Inputs: inc, dec. Outputs: has_credit, overflow_err. Parameter: CREDITS.
  - The FIFO stays inline.

Test Plan:
- Single flit {1,1,4'b0010,0,64'd5} pulsed at edge 0 -> out_valid pulse after edge 1; out_flit equals the input; credit[0] 4->3; fifo_count 1->0.
- Five pulses on VC0, no credit returns, CREDITS=4 -> four flits out on consecutive cycles; fifth held; fifo_count=1. One credit_in[0] pulse -> fifth flit sent on the next edge.
- Credits held at 0 while 6 flits are pulsed -> 4 buffered, in_ready=0, drop_count=2. Then simultaneous push and pop at full -> accepted, drop_count stays 2.
- Head on VC1 with credit[1]=0, next flit on VC0 with credits -> nothing sent (HOL). credit_in[1] -> VC1 flit then VC0 flit on consecutive cycles.
- credit_in[0] pulse at reset state -> credit_err=1, counter stays 4. Pop on VC0 plus credit_in[0] in the same cycle -> counter unchanged.
- rst_n low mid-burst with 3 buffered -> immediately fifo_count=0, out_valid=0, credits=4. in_send with in_flit[69]=0 -> ignored, no drop.
